// File: rtl/bsg_xui_pkg.sv
// Shared types for the XUI round-robin arbiter.
//   xui_cmd_e : command encoding driven on app_cmd_o
//   state_e   : arbiter run/drain/idle state
package bsg_xui_pkg;

  typedef enum logic [2:0] {
    XuiCmdWrite = 3'b000,
    XuiCmdRead  = 3'b001
  } xui_cmd_e;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StIdle
  } state_e;

  function automatic xui_cmd_e xui_cmd(input logic we);
    return we ? XuiCmdWrite : XuiCmdRead;
  endfunction

endpackage

// File: rtl/bsg_xui_tag_fifo.sv
// Read-tag FIFO: remembers which requester owns each outstanding read so returning data
// can be steered back in issue order.
//   clk_i, reset_i  : clock, asynchronous active-high reset (empties the FIFO)
//   push_i, data_i  : enqueue a tag (ignored when full)
//   pop_i, data_o   : dequeue the head tag (ignored when empty); data_o is the head
//   full_o, empty_o : occupancy flags
//   count_o         : current number of stored tags
module bsg_xui_tag_fifo #(
  parameter int unsigned width_p = 2,
  parameter int unsigned els_p   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       pop_i,
  output logic [width_p-1:0]         data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(els_p):0]     count_o
);

  localparam int unsigned PtrW = $clog2(els_p);
  localparam logic [PtrW:0]   CntOne  = (PtrW+1)'(1);
  localparam logic [PtrW:0]   CntFull = (PtrW+1)'(els_p);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [width_p-1:0] mem_q [els_p];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]      count_q, count_d;
  logic               push, pop;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push = push_i & ~full_o;
  assign pop  = pop_i & ~empty_o;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/bsg_xui_rr_arbiter.sv
// Round-robin arbiter multiplexing num_req_p requesters onto one Xilinx memory
// user interface (controller side). Writes are single-beat; reads are single-beat and
// their data is steered back to the issuing requester through a tag FIFO.
//   clk_i, reset_i          : clock, asynchronous active-high reset
//   req_v/we/addr/data/mask : per-requester command (mask bit 1 = byte not written)
//   req_ready_o             : one-hot command accept
//   resp_v_o, resp_data_o   : one-hot read-data valid, broadcast read data
//   drain_i, idle_o         : stop issuing and wait for outstanding reads; idle when done
//   err_o                   : sticky, read data arrived with no outstanding read
//   app_*                   : XUI command, write-data and read-data channels
module bsg_xui_rr_arbiter
  import bsg_xui_pkg::*;
#(
  parameter int unsigned addr_width_p = 28,
  parameter int unsigned data_width_p = 64,
  parameter int unsigned num_req_p    = 4,
  parameter int unsigned tag_els_p    = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,

  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p-1:0]                  req_we_i,
  input  logic [num_req_p*addr_width_p-1:0]     req_addr_i,
  input  logic [num_req_p*data_width_p-1:0]     req_data_i,
  input  logic [num_req_p*(data_width_p/8)-1:0] req_mask_i,
  output logic [num_req_p-1:0]                  req_ready_o,

  output logic [num_req_p-1:0]                  resp_v_o,
  output logic [data_width_p-1:0]               resp_data_o,

  input  logic                                  drain_i,
  output logic                                  idle_o,
  output logic                                  err_o,

  output logic [addr_width_p-1:0]               app_addr_o,
  output logic [2:0]                            app_cmd_o,
  output logic                                  app_en_o,
  input  logic                                  app_rdy_i,
  output logic                                  app_wdf_wren_o,
  output logic [data_width_p-1:0]               app_wdf_data_o,
  output logic [(data_width_p/8)-1:0]           app_wdf_mask_o,
  output logic                                  app_wdf_end_o,
  input  logic                                  app_wdf_rdy_i,
  input  logic                                  app_rd_data_valid_i,
  input  logic [data_width_p-1:0]               app_rd_data_i,
  input  logic                                  app_rd_data_end_i
);

  localparam int unsigned TagW  = $clog2(num_req_p);
  localparam int unsigned MaskW = data_width_p / 8;
  localparam int unsigned CntW  = $clog2(tag_els_p) + 1;
  localparam logic [TagW-1:0] LastReq = TagW'(num_req_p - 1);
  localparam logic [TagW:0]   NumReq  = (TagW+1)'(num_req_p);

  state_e            state_q, state_d;
  logic [TagW-1:0]   rr_q, rr_d;
  logic              err_q, err_d;

  logic [TagW-1:0]   grant;
  logic              grant_v;
  logic              grant_we;
  logic [TagW:0]     sum;
  logic [addr_width_p-1:0] grant_addr;
  logic [data_width_p-1:0] grant_data;
  logic [MaskW-1:0]        grant_mask;

  logic              issue;
  logic              tag_push, tag_pop;
  logic              tag_full, tag_empty;
  logic [TagW-1:0]   tag_head;
  logic [CntW-1:0]   tag_count;
  logic              drained;

  // Single-beat reads: the end-of-burst marker carries no information.
  logic unused_rd_end;
  assign unused_rd_end = app_rd_data_end_i;

  // First valid requester at or after rr_q, wrapping.
  always_comb begin
    grant   = rr_q;
    grant_v = 1'b0;
    sum     = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      sum = {1'b0, rr_q} + (TagW+1)'(k);
      if (sum >= NumReq) begin
        sum = sum - NumReq;
      end
      if (!grant_v && req_v_i[sum[TagW-1:0]]) begin
        grant   = sum[TagW-1:0];
        grant_v = 1'b1;
      end
    end
  end

  always_comb begin
    grant_addr = '0;
    grant_data = '0;
    grant_mask = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (grant == TagW'(i)) begin
        grant_addr = req_addr_i[i*addr_width_p +: addr_width_p];
        grant_data = req_data_i[i*data_width_p +: data_width_p];
        grant_mask = req_mask_i[i*MaskW +: MaskW];
      end
    end
  end

  assign grant_we = req_we_i[grant];

  // A full tag FIFO blocks reads even if a pop frees a slot this cycle.
  assign issue = ~reset_i & (state_q == StRun) & grant_v & app_rdy_i &
                 (grant_we ? app_wdf_rdy_i : ~tag_full);

  assign tag_push = issue & ~grant_we;
  assign tag_pop  = ~reset_i & app_rd_data_valid_i & ~tag_empty;

  bsg_xui_tag_fifo #(
    .width_p (TagW),
    .els_p   (tag_els_p)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (tag_push),
    .data_i  (grant),
    .pop_i   (tag_pop),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  // FIFO will be empty after this cycle (no pushes happen outside StRun).
  assign drained = tag_empty | (tag_pop & (tag_count == CntW'(1)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (drain_i) state_d = StDrain;
      end
      StDrain: begin
        if (!drain_i)    state_d = StRun;
        else if (drained) state_d = StIdle;
      end
      StIdle: begin
        if (!drain_i) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (issue) begin
      rr_d = (grant == LastReq) ? '0 : grant + TagW'(1);
    end
  end

  assign err_d = err_q | (app_rd_data_valid_i & tag_empty);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StRun;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready_o = '0;
    resp_v_o    = '0;
    if (issue) begin
      req_ready_o[grant] = 1'b1;
    end
    if (tag_pop) begin
      resp_v_o[tag_head] = 1'b1;
    end
  end

  assign resp_data_o    = app_rd_data_i;
  assign app_en_o       = issue;
  assign app_cmd_o      = xui_cmd(grant_we);
  assign app_addr_o     = grant_addr;
  assign app_wdf_wren_o = issue & grant_we;
  assign app_wdf_end_o  = issue & grant_we;
  assign app_wdf_data_o = grant_data;
  assign app_wdf_mask_o = grant_mask;
  assign idle_o         = (state_q == StIdle);
  assign err_o          = err_q;

endmodule

// File: tb/tb_bsg_xui_rr_arbiter.sv
module tb_bsg_xui_rr_arbiter;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int MW = DW / 8;
  localparam int TAGS = 2;

  logic            clk, reset;
  logic [N-1:0]    req_v, req_we, req_ready, resp_v;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*MW-1:0] req_mask;
  logic [DW-1:0]   resp_data;
  logic            drain, idle, err;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;
  logic            app_en, app_rdy, wren, wend, wdf_rdy, rd_valid, rd_end;
  logic [DW-1:0]   wdata, rd_data;
  logic [MW-1:0]   wmask;

  logic [AW-1:0]   addr_a [N];
  logic [DW-1:0]   data_a [N];
  logic [MW-1:0]   mask_a [N];

  always_comb begin
    req_addr = '0;
    req_data = '0;
    req_mask = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr_a[i];
      req_data[i*DW +: DW] = data_a[i];
      req_mask[i*MW +: MW] = mask_a[i];
    end
  end

  bsg_xui_rr_arbiter #(
    .addr_width_p (AW),
    .data_width_p (DW),
    .num_req_p    (N),
    .tag_els_p    (TAGS)
  ) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .req_v_i             (req_v),
    .req_we_i            (req_we),
    .req_addr_i          (req_addr),
    .req_data_i          (req_data),
    .req_mask_i          (req_mask),
    .req_ready_o         (req_ready),
    .resp_v_o            (resp_v),
    .resp_data_o         (resp_data),
    .drain_i             (drain),
    .idle_o              (idle),
    .err_o               (err),
    .app_addr_o          (app_addr),
    .app_cmd_o           (app_cmd),
    .app_en_o            (app_en),
    .app_rdy_i           (app_rdy),
    .app_wdf_wren_o      (wren),
    .app_wdf_data_o      (wdata),
    .app_wdf_mask_o      (wmask),
    .app_wdf_end_o       (wend),
    .app_wdf_rdy_i       (wdf_rdy),
    .app_rd_data_valid_i (rd_valid),
    .app_rd_data_i       (rd_data),
    .app_rd_data_end_i   (rd_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pointer as an int, outstanding tags as a queue,
  // mode 0=run 1=drain 2=idle. Evaluated on the falling edge, when inputs are stable.
  int       m_rr, m_st, g;
  bit       m_err, iss, pop, gwe;
  int       m_q[$];
  logic [1:0] gi, ci;
  logic [3:0] e_ready, e_resp;

  always @(negedge clk) begin
    if (reset) begin
      m_rr = 0;
      m_st = 0;
      m_err = 0;
      m_q.delete();
      chk("rst_app_en", 64'(app_en), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_wren", 64'(wren), 64'(0));
      chk("rst_wend", 64'(wend), 64'(0));
      chk("rst_resp_v", 64'(resp_v), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_idle", 64'(idle), 64'(0));
    end else begin
      g = -1;
      gi = 2'd0;
      for (int k = 0; k < N; k++) begin
        ci = 2'((m_rr + k) % N);
        if (g < 0 && req_v[ci]) begin
          g = int'(ci);
          gi = ci;
        end
      end
      gwe = (g >= 0) && req_we[gi];
      iss = (m_st == 0) && (g >= 0) && app_rdy &&
            (gwe ? wdf_rdy : (m_q.size() < TAGS));
      pop = rd_valid && (m_q.size() != 0);
      e_ready = iss ? (4'b0001 << gi) : 4'b0000;
      e_resp  = pop ? (4'b0001 << m_q[0]) : 4'b0000;

      chk("app_en", 64'(app_en), 64'(iss));
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("wdf_wren", 64'(wren), 64'(iss && gwe));
      chk("wdf_end", 64'(wend), 64'(iss && gwe));
      if (iss) begin
        chk("app_cmd", 64'(app_cmd), gwe ? 64'(0) : 64'(1));
        chk("app_addr", 64'(app_addr), 64'(addr_a[gi]));
        if (gwe) begin
          chk("wdf_data", 64'(wdata), 64'(data_a[gi]));
          chk("wdf_mask", 64'(wmask), 64'(mask_a[gi]));
        end
      end
      chk("resp_v", 64'(resp_v), 64'(e_resp));
      if (pop) chk("resp_data", 64'(resp_data), 64'(rd_data));
      chk("idle", 64'(idle), 64'(m_st == 2));
      chk("err", 64'(err), 64'(m_err));

      if (rd_valid && m_q.size() == 0) m_err = 1;
      if (pop) void'(m_q.pop_front());
      if (iss) begin
        m_rr = (g + 1) % N;
        if (!gwe) m_q.push_back(g);
      end
      case (m_st)
        0: if (drain) m_st = 1;
        1: if (!drain) m_st = 0; else if (m_q.size() == 0) m_st = 2;
        default: if (!drain) m_st = 0;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_v = '0;
    req_we = '0;
    drain = 1'b0;
    app_rdy = 1'b1;
    wdf_rdy = 1'b1;
    rd_valid = 1'b0;
    rd_data = '0;
    rd_end = 1'b0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'(28'h100 * i + 28'h11 * i);
      data_a[i] = 32'hA5A5_0000 + DW'(i * 32'h0101);
      mask_a[i] = MW'(i);
    end
    addr_a[0] = 28'h80;
    addr_a[2] = 28'h40;

    cyc(); cyc(); #2;
    chk("lit_reset_en", 64'(app_en), 64'(0));
    chk("lit_reset_idle", 64'(idle), 64'(0));
    cyc(); reset = 1'b0;

    // Read data with nothing outstanding -> sticky error, no response.
    cyc(); rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF; #2;
    chk("lit_spurious_resp_v", 64'(resp_v), 64'(0));
    cyc(); rd_valid = 1'b0; #2;
    chk("lit_err_set", 64'(err), 64'(1));
    repeat (3) cyc();
    #2 chk("lit_err_sticky", 64'(err), 64'(1));
    cyc(); reset = 1'b1; #2;
    chk("lit_err_cleared", 64'(err), 64'(0));
    cyc(); reset = 1'b0;

    // All four write continuously: grants rotate 0,1,2,3,0.
    cyc(); req_v = 4'hF; req_we = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("lit_rot_ready", 64'(req_ready), 64'(4'b0001 << (i % 4)));
      chk("lit_rot_cmd", 64'(app_cmd), 64'(0));
      chk("lit_rot_wren_end", 64'({wren, wend}), 64'(2'b11));
      cyc();
    end
    req_v = '0;

    // rr=1: requester 1 writes once so rr becomes 2.
    req_v = 4'b0010; req_we = 4'b0010; #2;
    chk("lit_w1_ready", 64'(req_ready), 64'(4'b0010));
    // Write data not ready: requester 3 read goes ahead, requester 1 write waits.
    cyc(); wdf_rdy = 1'b0; req_v = 4'b1010; req_we = 4'b0010; #2;
    chk("lit_r3_ready", 64'(req_ready), 64'(4'b1000));
    chk("lit_r3_cmd", 64'(app_cmd), 64'(1));
    cyc(); req_v = 4'b0010; #2;
    chk("lit_w1_blocked_en", 64'(app_en), 64'(0));
    cyc(); #2;
    chk("lit_w1_blocked_ready", 64'(req_ready), 64'(0));
    cyc(); req_v = '0; wdf_rdy = 1'b1; rd_valid = 1'b1; rd_data = 32'h3333_3333; #2;
    chk("lit_r3_resp", 64'(resp_v), 64'(4'b1000));
    // rr must now be 0: requesters 0 and 3 both valid -> 0 wins.
    cyc(); rd_valid = 1'b0; req_v = 4'b1001; req_we = 4'b1001; #2;
    chk("lit_rr_at_0", 64'(req_ready), 64'(4'b0001));
    cyc(); req_v = 4'b1000; #2;
    chk("lit_rr_then_3", 64'(req_ready), 64'(4'b1000));
    cyc(); req_v = '0;

    // Requester 2 reads 0x40, requester 0 reads 0x80, data returns in order.
    req_v = 4'b0100; req_we = 4'b0000; #2;
    chk("lit_rd2_ready", 64'(req_ready), 64'(4'b0100));
    chk("lit_rd2_addr", 64'(app_addr), 64'(28'h40));
    cyc(); req_v = 4'b0001; #2;
    chk("lit_rd0_addr", 64'(app_addr), 64'(28'h80));
    cyc(); req_v = '0; rd_valid = 1'b1; rd_data = 32'hD1D1_D1D1; #2;
    chk("lit_d1_resp_v", 64'(resp_v), 64'(4'b0100));
    chk("lit_d1_data", 64'(resp_data), 64'(32'hD1D1_D1D1));
    cyc(); rd_data = 32'hD2D2_D2D2; #2;
    chk("lit_d2_resp_v", 64'(resp_v), 64'(4'b0001));
    chk("lit_d2_data", 64'(resp_data), 64'(32'hD2D2_D2D2));
    cyc(); rd_valid = 1'b0;

    // Two-entry tag FIFO: third read stalls until a slot frees.
    req_v = 4'b0111; req_we = 4'b0000; #2;
    chk("lit_fill1", 64'(req_ready), 64'(4'b0010));
    cyc(); req_v = 4'b0101; #2;
    chk("lit_fill2", 64'(req_ready), 64'(4'b0100));
    cyc(); req_v = 4'b0001; #2;
    chk("lit_full_stall", 64'(req_ready), 64'(0));
    cyc(); rd_valid = 1'b1; rd_data = 32'h0000_1111; #2;
    chk("lit_full_pop_stall", 64'(req_ready), 64'(0));
    chk("lit_full_pop_resp", 64'(resp_v), 64'(4'b0010));
    cyc(); rd_valid = 1'b0; #2;
    chk("lit_third_issues", 64'(req_ready), 64'(4'b0001));
    cyc(); req_v = '0; rd_valid = 1'b1; rd_data = 32'h0000_2222; #2;
    chk("lit_ret_2", 64'(resp_v), 64'(4'b0100));
    cyc(); rd_data = 32'h0000_0000; #2;
    chk("lit_ret_0", 64'(resp_v), 64'(4'b0001));
    cyc(); rd_valid = 1'b0;

    // Drain with two outstanding reads.
    req_v = 4'b0110; req_we = 4'b0000;
    cyc(); req_v = 4'b0100;
    cyc(); req_v = '0; drain = 1'b1;
    cyc(); req_v = 4'b0001; req_we = 4'b0001; #2;
    chk("lit_drain_no_issue", 64'(app_en), 64'(0));
    chk("lit_drain_not_idle", 64'(idle), 64'(0));
    cyc(); rd_valid = 1'b1; rd_data = 32'hAAAA_0001; #2;
    chk("lit_drain_ret1", 64'(resp_v), 64'(4'b0010));
    cyc(); rd_data = 32'hAAAA_0002; #2;
    chk("lit_drain_ret2", 64'(resp_v), 64'(4'b0100));
    chk("lit_drain_ret2_idle", 64'(idle), 64'(0));
    cyc(); rd_valid = 1'b0; #2;
    chk("lit_idle", 64'(idle), 64'(1));
    cyc(); drain = 1'b0; #2;
    chk("lit_idle_hold_en", 64'(app_en), 64'(0));
    cyc(); #2;
    chk("lit_resume_idle", 64'(idle), 64'(0));
    chk("lit_resume_ready", 64'(req_ready), 64'(4'b0001));
    cyc(); req_v = '0;

    // Reset mid-operation discards the outstanding tag.
    req_v = 4'b0001; req_we = 4'b0000; #2;
    chk("lit_pre_reset_ready", 64'(req_ready), 64'(4'b0001));
    cyc(); req_v = '0; reset = 1'b1; #2;
    chk("lit_mid_reset_en", 64'(app_en), 64'(0));
    cyc(); reset = 1'b0;
    cyc(); rd_valid = 1'b1; rd_data = 32'h5555_5555; #2;
    chk("lit_post_reset_resp", 64'(resp_v), 64'(0));
    cyc(); rd_valid = 1'b0; #2;
    chk("lit_post_reset_err", 64'(err), 64'(1));
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
